soc_clk_en_ctrl: RTL and testbench
==================================

SOC_CLK_EN_CTRL -- requirements
Module: soc_clk_en_ctrl

Interface
REQ-001 Parameter IDLE_CYCLES, default 4: number of consecutive qualified-idle cycles in ARM before gating; legal range 1..255.
REQ-002 Parameter WAKE_CYCLES, default 2: number of cycles spent in WAKE before returning to RUN; legal range 1..255.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 sleep_req_i  input  1  core sleep request (core_sleep_o of cv32e40p), level.
REQ-006 bus_idle_i  input  1  high when the core has no outstanding instruction or data bus transactions.
REQ-007 irq_pending_i  input  1  any enabled interrupt pending, level.
REQ-008 debug_req_i  input  1  debug request, level.
REQ-009 force_on_i  input  1  test/debug override that keeps the core clock running.
REQ-010 cnt_clr_i  input  1  synchronous clear of gated_cycles_o.
REQ-011 clk_en_o  output  1  registered enable driven to en_i of cv32e40p_clock_gate.
REQ-012 sleeping_o  output  1  high while the FSM is in GATED.
REQ-013 wake_pulse_o  output  1  one-cycle pulse on each GATED->WAKE transition.
REQ-014 gated_cycles_o  output  32  saturating count of cycles spent in GATED.

Function
REQ-015 The block SHALL implement a four-state FSM: RUN, ARM, GATED, WAKE.
REQ-016 wake_evt is defined as irq_pending_i | debug_req_i | force_on_i | !sleep_req_i; idle_ok is defined as sleep_req_i & bus_idle_i & !irq_pending_i & !debug_req_i & !force_on_i.
REQ-017 RUN: on idle_ok, go to ARM and load the idle counter with 0; otherwise stay in RUN.
REQ-018 ARM: if !idle_ok, return to RUN in the next cycle; else increment the idle counter and, when it equals IDLE_CYCLES-1, go to GATED.
REQ-019 Consequently, IDLE_CYCLES consecutive idle_ok cycles in ARM SHALL lead to GATED, and any single non-idle cycle SHALL restart qualification from RUN.
REQ-020 GATED: on wake_evt, go to WAKE and load the wake counter with 0; otherwise stay in GATED.
REQ-021 WAKE: increment the wake counter and go to RUN when it equals WAKE_CYCLES-1; sleep_req_i and idle_ok SHALL be ignored in WAKE.
REQ-022 clk_en_o SHALL be a flop equal to 0 exactly in the cycles the FSM is in GATED and 1 in all other states.
REQ-023 clk_en_o SHALL fall in the first cycle of GATED and rise in the first cycle of WAKE, i.e. one clk_i cycle after the wake event is sampled.
REQ-024 clk_en_o SHALL have no combinational path from any input.
REQ-025 sleeping_o SHALL be registered and identical to !clk_en_o.
REQ-026 wake_pulse_o SHALL be high for exactly the first cycle of WAKE.
REQ-027 gated_cycles_o SHALL increment by 1 in every cycle the FSM is in GATED.
REQ-028 gated_cycles_o SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-029 cnt_clr_i SHALL set gated_cycles_o to 0 in the next cycle, overriding a simultaneous increment.
REQ-030 cnt_clr_i SHALL NOT affect the FSM.
REQ-031 Simultaneous idle_ok and wake_evt cannot occur by definition; when force_on_i is high, the FSM SHALL never leave RUN/WAKE towards GATED.
REQ-032 Idle and wake counters SHALL be $clog2(256) = 8 bits wide; no counter SHALL wrap within legal parameter ranges.

Reset
REQ-033 On rst_ni low at a clock edge: state=RUN, clk_en_o=1, sleeping_o=0, wake_pulse_o=0, gated_cycles_o=0, and both internal counters=0.
REQ-034 Reset asserted in any state, including GATED, SHALL return to RUN with clk_en_o=1 on the next edge, so the core is clocked during its own reset.

Verification
REQ-035 Reset release, then sleep_req_i=1, bus_idle_i=1, other inputs 0, with IDLE_CYCLES=4 -> 1 cycle RUN, 4 cycles ARM, then clk_en_o=0 and sleeping_o=1; gated_cycles_o counts 1,2,3...
REQ-036 In GATED, assert irq_pending_i for one cycle -> next cycle clk_en_o=1 and wake_pulse_o=1 (one cycle only); 2 WAKE cycles, then RUN; gated_cycles_o holds its value.
REQ-037 In ARM, drop bus_idle_i for 1 cycle on the 3rd ARM cycle -> return to RUN, clk_en_o never falls; full 4-cycle qualification repeats before gating.
REQ-038 force_on_i=1 with sleep_req_i=1 and bus_idle_i=1 for 100 cycles -> clk_en_o stays 1 and the FSM never enters ARM.
REQ-039 Preload gated_cycles_o near saturation by forcing it to 32'hFFFF_FFFE, stay GATED 5 cycles -> holds at 32'hFFFF_FFFF; cnt_clr_i=1 while GATED -> 0 next cycle, then counts from 1.
REQ-040 rst_ni=0 for one cycle while GATED -> next cycle clk_en_o=1, sleeping_o=0, gated_cycles_o=0, state RUN.

Source files
------------

// File: rtl/soc_clk_en_ctrl.sv
// soc_clk_en_ctrl
// ----------------------------------------------------------------------------
// Sleep / wake sequencer for the core clock. It qualifies a sleep request for
// IDLE_CYCLES consecutive idle cycles, then drops the clock enable that feeds
// the core's integrated clock gate. On any wake event it raises the enable
// again, holds the core in a WAKE window for WAKE_CYCLES cycles, and then
// returns to RUN.
//
// There is no valid/ready handshake on this block: every input is a level
// and is sampled on each rising edge of clk_i.
//
// Parameters
//   IDLE_CYCLES    consecutive qualified-idle cycles in ARM before gating (1..255)
//   WAKE_CYCLES    cycles spent in WAKE before returning to RUN (1..255)
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_ni         synchronous active-low reset
//   sleep_req_i    core sleep request (level)
//   bus_idle_i     no outstanding instruction/data bus transactions
//   irq_pending_i  an enabled interrupt is pending (level)
//   debug_req_i    debug request (level)
//   force_on_i     override that keeps the core clock running
//   cnt_clr_i      synchronous clear of gated_cycles_o
//   clk_en_o       registered enable for the core clock gate (0 only in GATED)
//   sleeping_o     registered, high while in GATED (always !clk_en_o)
//   wake_pulse_o   one-cycle pulse in the first cycle of WAKE
//   gated_cycles_o saturating count of cycles spent in GATED
//   state_o        current FSM state (0=RUN, 1=ARM, 2=GATED, 3=WAKE), debug only
// ----------------------------------------------------------------------------
module soc_clk_en_ctrl #(
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sleep_req_i,
    input  logic        bus_idle_i,
    input  logic        irq_pending_i,
    input  logic        debug_req_i,
    input  logic        force_on_i,
    input  logic        cnt_clr_i,
    output logic        clk_en_o,
    output logic        sleeping_o,
    output logic        wake_pulse_o,
    output logic [31:0] gated_cycles_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    // Counters are wide enough for the largest legal parameter (255), so the
    // terminal compare is always reached before the counter could wrap.
    localparam int unsigned CNT_W     = $clog2(256);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   wake_cnt;

    logic               wake_evt;
    logic               idle_ok;
    logic               gated_nxt;

    // idle_ok and wake_evt are mutually exclusive: idle_ok needs sleep_req_i
    // high and all three wake sources low, which is exactly !wake_evt & bus_idle.
    assign wake_evt = irq_pending_i | debug_req_i | force_on_i | !sleep_req_i;
    assign idle_ok  = sleep_req_i & bus_idle_i & !irq_pending_i &
                      !debug_req_i & !force_on_i;

    // High when the FSM will be in GATED during the next cycle: either the
    // last qualifying ARM cycle, or GATED with no wake event. Both the enable
    // flop and the gated-cycle counter key off this so that they line up with
    // the state register exactly.
    always_comb begin
        gated_nxt = 1'b0;
        case (state)
            ST_ARM:   gated_nxt = idle_ok && (idle_cnt == IDLE_LAST);
            ST_GATED: gated_nxt = !wake_evt;
            default:  gated_nxt = 1'b0;
        endcase
    end

    // Main FSM with its registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_RUN;
            idle_cnt     <= '0;
            wake_cnt     <= '0;
            clk_en_o     <= 1'b1;
            sleeping_o   <= 1'b0;
            wake_pulse_o <= 1'b0;
        end else begin
            // Enable and sleeping flag are pure flops of the next-state decode,
            // so clk_en_o has no combinational path from any input.
            clk_en_o     <= !gated_nxt;
            sleeping_o   <= gated_nxt;
            wake_pulse_o <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (idle_ok) begin
                        state    <= ST_ARM;
                        idle_cnt <= '0;
                    end
                end

                ST_ARM: begin
                    if (!idle_ok) begin
                        // A single non-idle cycle restarts qualification.
                        state <= ST_RUN;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == IDLE_LAST) begin
                            state <= ST_GATED;
                        end
                    end
                end

                ST_GATED: begin
                    if (wake_evt) begin
                        state        <= ST_WAKE;
                        wake_cnt     <= '0;
                        wake_pulse_o <= 1'b1;
                    end
                end

                ST_WAKE: begin
                    // Sleep request and idle qualification are ignored here;
                    // the WAKE window always runs to completion.
                    wake_cnt <= wake_cnt + 1'b1;
                    if (wake_cnt == WAKE_LAST) begin
                        state <= ST_RUN;
                    end
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Gated-cycle counter. It counts the cycle about to be spent in GATED, so
    // the first GATED cycle already shows 1. Clear wins over increment, and
    // the count sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gated_cycles_o <= '0;
        end else if (cnt_clr_i) begin
            gated_cycles_o <= '0;
        end else if (gated_nxt && (gated_cycles_o != 32'hFFFF_FFFF)) begin
            gated_cycles_o <= gated_cycles_o + 32'd1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_soc_clk_en_ctrl.sv
// Directed testbench for soc_clk_en_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_soc_clk_en_ctrl;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_GATED = 2'd2;
  localparam logic [1:0] S_WAKE  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sleep_req;
  logic        bus_idle;
  logic        irq_pending;
  logic        debug_req;
  logic        force_on;
  logic        cnt_clr;
  logic        clk_en;
  logic        sleeping;
  logic        wake_pulse;
  logic [31:0] gated_cycles;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  soc_clk_en_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sleep_req_i   (sleep_req),
    .bus_idle_i    (bus_idle),
    .irq_pending_i (irq_pending),
    .debug_req_i   (debug_req),
    .force_on_i    (force_on),
    .cnt_clr_i     (cnt_clr),
    .clk_en_o      (clk_en),
    .sleeping_o    (sleeping),
    .wake_pulse_o  (wake_pulse),
    .gated_cycles_o(gated_cycles),
    .state_o       (state)
  );

  // Advance one full cycle, ending on a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; sleep_req = 1'b0; bus_idle = 1'b0; irq_pending = 1'b0;
    debug_req = 1'b0; force_on = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    step(); step();
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL reset_clk_en: got %b expected 1", clk_en); end
    n_checks++; if (sleeping !== 1'b0) begin n_fail++; $display("FAIL reset_sleeping: got %b expected 0", sleeping); end
    n_checks++; if (wake_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wake_pulse: got %b expected 0", wake_pulse); end
    n_checks++; if (gated_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_gated_cycles: got %0h expected 0", gated_cycles); end
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, S_RUN); end
  endtask

  task automatic test_gating();
    rst_n = 1'b1; sleep_req = 1'b1; bus_idle = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++; if (state !== S_ARM) begin n_fail++; $display("FAIL gate_arm_state[%0d]: got %0d expected %0d", i, state, S_ARM); end
      n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL gate_arm_clk_en[%0d]: got %b expected 1", i, clk_en); end
    end
    step();
    n_checks++; if (state !== S_GATED) begin n_fail++; $display("FAIL gate_state: got %0d expected %0d", state, S_GATED); end
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL gate_clk_en: got %b expected 0", clk_en); end
    n_checks++; if (sleeping !== 1'b1) begin n_fail++; $display("FAIL gate_sleeping: got %b expected 1", sleeping); end
    n_checks++; if (gated_cycles !== 32'd1) begin n_fail++; $display("FAIL gate_count1: got %0d expected 1", gated_cycles); end
    for (int i = 2; i <= 3; i++) begin
      step();
      n_checks++; if (gated_cycles !== 32'(i)) begin n_fail++; $display("FAIL gate_count%0d: got %0d expected %0d", i, gated_cycles, i); end
      n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL gate_hold_clk_en[%0d]: got %b expected 0", i, clk_en); end
    end
  endtask

  task automatic test_wake_irq();
    irq_pending = 1'b1;
    step();
    n_checks++; if (state !== S_WAKE) begin n_fail++; $display("FAIL wake_state: got %0d expected %0d", state, S_WAKE); end
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL wake_clk_en: got %b expected 1", clk_en); end
    n_checks++; if (sleeping !== 1'b0) begin n_fail++; $display("FAIL wake_sleeping: got %b expected 0", sleeping); end
    n_checks++; if (wake_pulse !== 1'b1) begin n_fail++; $display("FAIL wake_pulse_first: got %b expected 1", wake_pulse); end
    n_checks++; if (gated_cycles !== 32'd3) begin n_fail++; $display("FAIL wake_count_hold: got %0d expected 3", gated_cycles); end
    irq_pending = 1'b0;
    step();
    n_checks++; if (state !== S_WAKE) begin n_fail++; $display("FAIL wake2_state: got %0d expected %0d", state, S_WAKE); end
    n_checks++; if (wake_pulse !== 1'b0) begin n_fail++; $display("FAIL wake_pulse_second: got %b expected 0", wake_pulse); end
    n_checks++; if (gated_cycles !== 32'd3) begin n_fail++; $display("FAIL wake2_count_hold: got %0d expected 3", gated_cycles); end
    step();
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL wake_to_run: got %0d expected %0d", state, S_RUN); end
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL wake_run_clk_en: got %b expected 1", clk_en); end
    sleep_req = 1'b0;
    step();
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL wake_stay_run: got %0d expected %0d", state, S_RUN); end
  endtask

  task automatic test_arm_abort();
    sleep_req = 1'b1; bus_idle = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (state !== S_ARM) begin n_fail++; $display("FAIL abort_arm[%0d]: got %0d expected %0d", i, state, S_ARM); end
    end
    bus_idle = 1'b0;   // third ARM cycle is not idle
    step();
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL abort_to_run: got %0d expected %0d", state, S_RUN); end
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL abort_clk_en: got %b expected 1", clk_en); end
    bus_idle = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++; if (state !== S_ARM) begin n_fail++; $display("FAIL requal_arm[%0d]: got %0d expected %0d", i, state, S_ARM); end
      n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL requal_clk_en[%0d]: got %b expected 1", i, clk_en); end
    end
    step();
    n_checks++; if (state !== S_GATED) begin n_fail++; $display("FAIL requal_gated: got %0d expected %0d", state, S_GATED); end
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL requal_gated_clk_en: got %b expected 0", clk_en); end
    n_checks++; if (gated_cycles !== 32'd4) begin n_fail++; $display("FAIL requal_count: got %0d expected 4", gated_cycles); end
  endtask

  task automatic test_wake_debug();
    // Wake from GATED through debug_req; sleep_req stays high during WAKE
    // and must not cut the window short.
    debug_req = 1'b1;
    step();
    n_checks++; if (wake_pulse !== 1'b1) begin n_fail++; $display("FAIL dbg_wake_pulse: got %b expected 1", wake_pulse); end
    n_checks++; if (state !== S_WAKE) begin n_fail++; $display("FAIL dbg_wake_state: got %0d expected %0d", state, S_WAKE); end
    debug_req = 1'b0;
    step();
    n_checks++; if (state !== S_WAKE) begin n_fail++; $display("FAIL dbg_wake2_state: got %0d expected %0d", state, S_WAKE); end
    sleep_req = 1'b0;
    step();
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL dbg_to_run: got %0d expected %0d", state, S_RUN); end
  endtask

  task automatic test_force_on();
    force_on = 1'b1; sleep_req = 1'b1; bus_idle = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      n_checks++; if (state !== S_RUN || clk_en !== 1'b1) begin
        n_fail++; $display("FAIL force_on[%0d]: got state %0d clk_en %b expected state %0d clk_en 1", i, state, clk_en, S_RUN);
      end
    end
    force_on = 1'b0;
  endtask

  task automatic test_saturation();
    // Inputs left idle by the previous scenario: 4 ARM cycles then GATED.
    repeat (5) step();
    n_checks++; if (state !== S_GATED) begin n_fail++; $display("FAIL sat_gated: got %0d expected %0d", state, S_GATED); end
    force dut.gated_cycles_o = 32'hFFFF_FFFE;
    #1;
    release dut.gated_cycles_o;
    step();
    n_checks++; if (gated_cycles !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_reach: got %0h expected ffffffff", gated_cycles); end
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++; if (gated_cycles !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold[%0d]: got %0h expected ffffffff", i, gated_cycles); end
    end
    cnt_clr = 1'b1;
    step();
    n_checks++; if (gated_cycles !== 32'd0) begin n_fail++; $display("FAIL clr_zero: got %0h expected 0", gated_cycles); end
    n_checks++; if (state !== S_GATED) begin n_fail++; $display("FAIL clr_fsm_unaffected: got %0d expected %0d", state, S_GATED); end
    cnt_clr = 1'b0;
    step();
    n_checks++; if (gated_cycles !== 32'd1) begin n_fail++; $display("FAIL clr_count1: got %0d expected 1", gated_cycles); end
    step();
    n_checks++; if (gated_cycles !== 32'd2) begin n_fail++; $display("FAIL clr_count2: got %0d expected 2", gated_cycles); end
  endtask

  task automatic test_reset_in_gated();
    rst_n = 1'b0;
    step();
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL rstg_clk_en: got %b expected 1", clk_en); end
    n_checks++; if (sleeping !== 1'b0) begin n_fail++; $display("FAIL rstg_sleeping: got %b expected 0", sleeping); end
    n_checks++; if (gated_cycles !== 32'd0) begin n_fail++; $display("FAIL rstg_count: got %0d expected 0", gated_cycles); end
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL rstg_state: got %0d expected %0d", state, S_RUN); end
    n_checks++; if (wake_pulse !== 1'b0) begin n_fail++; $display("FAIL rstg_wake_pulse: got %b expected 0", wake_pulse); end
    rst_n = 1'b1; sleep_req = 1'b0;
    step();
    n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL rstg_after: got %0d expected %0d", state, S_RUN); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_gating();
    test_wake_irq();
    test_arm_abort();
    test_wake_debug();
    test_force_on();
    test_saturation();
    test_reset_in_gated();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
